// File: rtl/vga_ctrl_pkg.sv
// Shared VGA timing defaults, no-request code and RGB444 colours for this block and the picture block.
// Constants only: no logic, no latency, no flow control.
package vga_ctrl_pkg;

    localparam logic [9:0] VGA_H_SYNC   = 10'd96;
    localparam logic [9:0] VGA_H_BACK   = 10'd48;
    localparam logic [9:0] VGA_H_VALID  = 10'd640;
    localparam logic [9:0] VGA_H_FRONT  = 10'd16;
    localparam logic [9:0] VGA_V_SYNC   = 10'd2;
    localparam logic [9:0] VGA_V_BACK   = 10'd33;
    localparam logic [9:0] VGA_V_VALID  = 10'd480;
    localparam logic [9:0] VGA_V_FRONT  = 10'd10;
    localparam logic       VGA_SYNC_POL = 1'b0;

    // Outside every legal coordinate as long as each axis total stays <= 1023.
    localparam logic [9:0] PIX_NO_REQ = 10'd1023;

    localparam logic [11:0] RGB_RED     = 12'hf00;
    localparam logic [11:0] RGB_ORANGE  = 12'hf80;
    localparam logic [11:0] RGB_YELLOW  = 12'hff0;
    localparam logic [11:0] RGB_GREEN   = 12'h0f0;
    localparam logic [11:0] RGB_CYAN    = 12'h0ff;
    localparam logic [11:0] RGB_BLUE    = 12'h00f;
    localparam logic [11:0] RGB_PURPLE  = 12'hf0f;
    localparam logic [11:0] RGB_WHITE   = 12'hfff;
    localparam logic [11:0] RGB_GRAY    = 12'h888;
    localparam logic [11:0] RGB_BLACK   = 12'h000;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pix_pos_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// One VGA axis counter (sync/back/valid/front) with window decodes; counts when inc is high.
// Decodes are combinational from the registered count; no back-pressure.
module vga_axis_cnt
    import vga_ctrl_pkg::*;
#(
    parameter logic [9:0] SYNC  = VGA_H_SYNC,
    parameter logic [9:0] BACK  = VGA_H_BACK,
    parameter logic [9:0] VALID = VGA_H_VALID,
    parameter logic [9:0] FRONT = VGA_H_FRONT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [9:0] cnt,
    output logic       wrap,
    output logic       in_sync,
    output logic       in_valid,
    output logic       in_req
);

    localparam logic [9:0] TOTAL = SYNC + BACK + VALID + FRONT;
    localparam logic [9:0] START = SYNC + BACK;
    localparam logic [9:0] STOP  = START + VALID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 10'd0;
        end else if (inc) begin
            cnt <= wrap ? 10'd0 : cnt + 10'd1;
        end
    end

    // wrap is qualified with inc so the V instance flags only the line-end edge.
    assign wrap     = inc && (cnt == TOTAL - 10'd1);
    assign in_sync  = (cnt < SYNC);
    assign in_valid = (cnt >= START) && (cnt < STOP);
    assign in_req   = (cnt >= START - 10'd1) && (cnt < STOP - 10'd1);

endmodule

// File: rtl/vga_ctrl.sv
// 640x480@60 VGA timing: pix_x/pix_y lead rgb by one clock; hsync/vsync/frame_start registered.
// No back-pressure: pix_data must return exactly one clock after each request.
module vga_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter logic [9:0] H_SYNC   = VGA_H_SYNC,
    parameter logic [9:0] H_BACK   = VGA_H_BACK,
    parameter logic [9:0] H_VALID  = VGA_H_VALID,
    parameter logic [9:0] H_FRONT  = VGA_H_FRONT,
    parameter logic [9:0] V_SYNC   = VGA_V_SYNC,
    parameter logic [9:0] V_BACK   = VGA_V_BACK,
    parameter logic [9:0] V_VALID  = VGA_V_VALID,
    parameter logic [9:0] V_FRONT  = VGA_V_FRONT,
    parameter logic       SYNC_POL = VGA_SYNC_POL
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [11:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        rgb_valid,
    output logic        frame_start
);

    localparam logic [9:0] HS = H_SYNC + H_BACK;
    localparam logic [9:0] VS = V_SYNC + V_BACK;

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       h_wrap;
    logic       h_sync;
    logic       h_valid;
    logic       h_req;
    logic       v_wrap;
    logic       v_sync;
    logic       v_valid;
    logic       pix_req;
    logic       hs_nxt;
    logic       vs_nxt;
    pix_pos_t   req_pos;

    vga_axis_cnt #(
        .SYNC  (H_SYNC),
        .BACK  (H_BACK),
        .VALID (H_VALID),
        .FRONT (H_FRONT)
    ) u_h_cnt (
        .clk      (vga_clk),
        .rst_n    (sys_rst_n),
        .inc      (1'b1),
        .cnt      (cnt_h),
        .wrap     (h_wrap),
        .in_sync  (h_sync),
        .in_valid (h_valid),
        .in_req   (h_req)
    );

    vga_axis_cnt #(
        .SYNC  (V_SYNC),
        .BACK  (V_BACK),
        .VALID (V_VALID),
        .FRONT (V_FRONT)
    ) u_v_cnt (
        .clk      (vga_clk),
        .rst_n    (sys_rst_n),
        .inc      (h_wrap),
        .cnt      (cnt_v),
        .wrap     (v_wrap),
        .in_sync  (v_sync),
        .in_valid (v_valid),
        .in_req   ()
    );

    // Vertical data is line-granular, so the request leads only in X.
    assign pix_req   = h_req && v_valid;
    assign req_pos.x = pix_req ? cnt_h - (HS - 10'd1) : PIX_NO_REQ;
    assign req_pos.y = pix_req ? cnt_v - VS : PIX_NO_REQ;
    assign pix_x     = req_pos.x;
    assign pix_y     = req_pos.y;

    assign rgb_valid = h_valid && v_valid;
    assign rgb       = rgb_valid ? pix_data : RGB_BLACK;

    // Sync decode of the count about to be loaded, so the registered pins track the live counters.
    assign hs_nxt = h_wrap || (h_sync && (cnt_h != H_SYNC - 10'd1));
    assign vs_nxt = h_wrap ? (v_wrap || (v_sync && (cnt_v != V_SYNC - 10'd1))) : v_sync;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_nxt ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_nxt ? SYNC_POL : ~SYNC_POL;
            frame_start <= h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl: full-size timing over the first 36 lines plus mid-frame reset,
// and a shrunken active-high instance run over three whole frames.
module tb_vga_ctrl;

    logic vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    logic        rst_a_n, rst_b_n;
    logic        ovr_a;
    logic [11:0] pd_a_q, pd_b_q, pix_data_a, pix_data_b;
    logic [9:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b;
    logic        hsync_a, vsync_a, rgb_valid_a, frame_start_a;
    logic        hsync_b, vsync_b, rgb_valid_b, frame_start_b;
    logic [11:0] rgb_a, rgb_b;

    int n_chk  = 0;
    int n_fail = 0;

    int th, tv, bh, bv;
    bit first_a, first_b;

    // Picture block stand-in: returns the requested X one clock later.
    always @(posedge vga_clk) begin
        pd_a_q <= {2'b00, pix_x_a};
        pd_b_q <= {2'b00, pix_x_b};
    end
    assign pix_data_a = ovr_a ? 12'hf00 : pd_a_q;
    assign pix_data_b = pd_b_q;

    vga_ctrl u_dut_a (
        .vga_clk     (vga_clk),
        .sys_rst_n   (rst_a_n),
        .pix_data    (pix_data_a),
        .pix_x       (pix_x_a),
        .pix_y       (pix_y_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .rgb         (rgb_a),
        .rgb_valid   (rgb_valid_a),
        .frame_start (frame_start_a)
    );

    vga_ctrl #(
        .H_SYNC   (10'd4),
        .H_BACK   (10'd2),
        .H_VALID  (10'd8),
        .H_FRONT  (10'd2),
        .V_SYNC   (10'd1),
        .V_BACK   (10'd1),
        .V_VALID  (10'd4),
        .V_FRONT  (10'd1),
        .SYNC_POL (1'b1)
    ) u_dut_b (
        .vga_clk     (vga_clk),
        .sys_rst_n   (rst_b_n),
        .pix_data    (pix_data_b),
        .pix_x       (pix_x_b),
        .pix_y       (pix_y_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .rgb         (rgb_b),
        .rgb_valid   (rgb_valid_b),
        .frame_start (frame_start_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and step the position models.
    task automatic tick();
        @(posedge vga_clk);
        #1;
        if (rst_a_n) begin
            first_a = 1'b0;
            if (th == 799) begin
                th = 0;
                tv = (tv == 524) ? 0 : tv + 1;
            end else begin
                th++;
            end
        end
        if (rst_b_n) begin
            first_b = 1'b0;
            if (bh == 15) begin
                bh = 0;
                bv = (bv == 6) ? 0 : bv + 1;
            end else begin
                bh++;
            end
        end
    endtask

    task automatic check_reset_a();
        chk("rst_pix_x", 32'(pix_x_a), 32'd1023);
        chk("rst_pix_y", 32'(pix_y_a), 32'd1023);
        chk("rst_hsync", 32'(hsync_a), 32'd1);
        chk("rst_vsync", 32'(vsync_a), 32'd1);
        chk("rst_rgb", 32'(rgb_a), 32'h000);
        chk("rst_rgb_valid", 32'(rgb_valid_a), 32'd0);
        chk("rst_frame_start", 32'(frame_start_a), 32'd0);
    endtask

    task automatic check_a();
        bit req, vis;
        int ex_rgb;
        req = (th >= 143) && (th < 783) && (tv >= 35) && (tv < 515);
        vis = (th >= 144) && (th < 784) && (tv >= 35) && (tv < 515);
        ex_rgb = !vis ? 0 : (ovr_a ? 'hf00 : th - 144);
        chk("a_pix_x", 32'(pix_x_a), req ? 32'(th - 143) : 32'd1023);
        chk("a_pix_y", 32'(pix_y_a), req ? 32'(tv - 35) : 32'd1023);
        chk("a_rgb_valid", 32'(rgb_valid_a), 32'(vis));
        chk("a_rgb", 32'(rgb_a), 32'(ex_rgb));
        chk("a_hsync", 32'(hsync_a), (first_a || th >= 96) ? 32'd1 : 32'd0);
        chk("a_vsync", 32'(vsync_a), (first_a || tv >= 2) ? 32'd1 : 32'd0);
        chk("a_frame_start", 32'(frame_start_a), (th == 0 && tv == 0 && !first_a) ? 32'd1 : 32'd0);
    endtask

    task automatic check_b();
        bit req, vis;
        req = (bh >= 5) && (bh < 13) && (bv >= 2) && (bv < 6);
        vis = (bh >= 6) && (bh < 14) && (bv >= 2) && (bv < 6);
        chk("b_pix_x", 32'(pix_x_b), req ? 32'(bh - 5) : 32'd1023);
        chk("b_pix_y", 32'(pix_y_b), req ? 32'(bv - 2) : 32'd1023);
        chk("b_rgb_valid", 32'(rgb_valid_b), 32'(vis));
        chk("b_rgb", 32'(rgb_b), vis ? 32'(bh - 6) : 32'd0);
        chk("b_hsync", 32'(hsync_b), (!first_b && bh < 4) ? 32'd1 : 32'd0);
        chk("b_vsync", 32'(vsync_b), (!first_b && bv < 1) ? 32'd1 : 32'd0);
        chk("b_frame_start", 32'(frame_start_b), (bh == 0 && bv == 0 && !first_b) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int vis_cnt, fs_cnt, last_fs, max_x, max_y, min_x, min_y;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ovr_a   = 1'b0;
        th = 0; tv = 0; bh = 0; bv = 0;
        first_a = 1'b1;
        first_b = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        check_reset_a();

        // Full-size instance: lines 0..2 and 34..35 checked cycle by cycle.
        @(negedge vga_clk);
        rst_a_n = 1'b1;
        #1;
        check_a();
        while (!(tv == 35 && th == 400)) begin
            tick();
            if (tv <= 2 || tv == 34 || tv == 35)
                check_a();
        end

        // Mid-line reset while a visible pixel with known colour is on rgb.
        ovr_a = 1'b1;
        tick();
        chk("pre_rst_rgb", 32'(rgb_a), 32'hf00);
        check_a();
        #5;
        rst_a_n = 1'b0;
        #1;
        check_reset_a();
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        rst_a_n = 1'b1;
        th = 0; tv = 0;
        first_a = 1'b1;
        #1;
        check_a();
        ovr_a = 1'b0;
        repeat (2400) begin
            tick();
            check_a();
        end

        // Shrunken active-high instance over three frames (112 clocks each).
        @(negedge vga_clk);
        rst_b_n = 1'b1;
        bh = 0; bv = 0;
        first_b = 1'b1;
        #1;
        check_b();
        vis_cnt = 0; fs_cnt = 0; last_fs = 0;
        max_x = 0; max_y = 0; min_x = 1023; min_y = 1023;
        for (int k = 1; k <= 336; k++) begin
            tick();
            check_b();
            if (rgb_valid_b) vis_cnt++;
            if (pix_x_b != 10'd1023) begin
                if (int'(pix_x_b) > max_x) max_x = int'(pix_x_b);
                if (int'(pix_x_b) < min_x) min_x = int'(pix_x_b);
                if (int'(pix_y_b) > max_y) max_y = int'(pix_y_b);
                if (int'(pix_y_b) < min_y) min_y = int'(pix_y_b);
            end
            if (frame_start_b) begin
                fs_cnt++;
                chk("b_fs_period", 32'(k - last_fs), 32'd112);
                last_fs = k;
            end
        end
        chk("b_vis_per_3frames", 32'(vis_cnt), 32'd96);
        chk("b_fs_count", 32'(fs_cnt), 32'd3);
        chk("b_max_x", 32'(max_x), 32'd7);
        chk("b_min_x", 32'(min_x), 32'd0);
        chk("b_max_y", 32'(max_y), 32'd3);
        chk("b_min_y", 32'(min_y), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
